// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 framebuffer controller.
// The CLEAR state only exists when HUB75_FB_CLEAR_EN is defined.
package hub75_pkg;

  localparam int HPIXEL_DEF       = 64;
  localparam int VPIXEL_DEF       = 64;
  localparam int BPP_DEF          = 8;
  localparam int SEGMENTS_DEF     = 2;
  localparam int FRAME_PIXELS_DEF = HPIXEL_DEF * VPIXEL_DEF;
  localparam int ADDR_WIDTH_DEF   = $clog2(FRAME_PIXELS_DEF);

  // One {B,G,R} pixel word at the default colour depth.
  typedef logic [3*BPP_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    FB_READY     = 2'd0,
    FB_SWAP_WAIT = 2'd1
`ifdef HUB75_FB_CLEAR_EN
    ,
    FB_CLEAR     = 2'd2
`endif
  } fb_state_e;

  // Segment-select width; a single-segment panel still gets a 1-bit field.
  function automatic int seg_width(input int segments);
    return (segments > 1) ? $clog2(segments) : 1;
  endfunction

endpackage

// File: rtl/hub75_fb_clear.sv
// Clear engine address counter: walks every framebuffer address once after
// a start pulse. Only instantiated when HUB75_FB_CLEAR_EN is defined.
module hub75_fb_clear #(
  parameter int depth_p      = 4096,
  parameter int addr_width_p = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic [addr_width_p-1:0] addr,
  output logic                    done
);

  localparam logic [addr_width_p-1:0] last_addr = addr_width_p'(depth_p - 1);

  assign done = busy && (addr == last_addr);

  // Step one address per cycle while busy and stop after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      addr <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        addr <= '0;
      end else begin
        addr <= addr + 1'b1;
      end
    end else if (start) begin
      busy <= 1'b1;
      addr <= '0;
    end
  end

endmodule

// File: rtl/hub75_fb_ctrl.sv
// Double-buffered framebuffer controller: host writes land in the back bank,
// swaps are applied only at frame boundaries while the scanner is running.
// Optional clear engine enabled by defining HUB75_FB_CLEAR_EN.
module hub75_fb_ctrl
  import hub75_pkg::*;
#(
  parameter int hpixel_p     = HPIXEL_DEF,
  parameter int vpixel_p     = VPIXEL_DEF,
  parameter int bpp_p        = BPP_DEF,
  parameter int segments_p   = SEGMENTS_DEF,
  localparam int addr_width_p = $clog2(hpixel_p * vpixel_p),
  localparam int seg_width_p  = seg_width(segments_p)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_run,
  input  logic                    i_frame_end,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [addr_width_p-1:0] i_wr_addr,
  input  logic [seg_width_p-1:0]  i_wr_seg,
  input  logic [3*bpp_p-1:0]      i_wr_data,
  input  logic                    i_swap_req,
  input  logic                    i_clear_req,
  output logic                    o_disp_enable,
  output logic                    o_front_sel,
  output logic                    o_mem_we,
  output logic                    o_mem_wbank,
  output logic [addr_width_p-1:0] o_mem_waddr,
  output logic [segments_p-1:0]   o_mem_wseg_mask,
  output logic [3*bpp_p-1:0]      o_mem_wdata,
  output logic                    o_swap_pending,
  output logic                    o_swap_done,
  output logic                    o_clear_busy,
  output logic [15:0]             o_frame_cnt
);

  fb_state_e state_q, state_d;
  logic      pending_q, pending_d;
  logic      active_q;
  logic      apply_swap;
  logic      swap_want;
  logic      wr_accept;

  logic                    wr_we_q;
  logic                    wr_bank_q;
  logic [addr_width_p-1:0] wr_addr_q;
  logic [segments_p-1:0]   wr_mask_q;
  logic [3*bpp_p-1:0]      wr_data_q;

  logic                    clear_busy;
  logic [addr_width_p-1:0] clear_addr;

`ifdef HUB75_FB_CLEAR_EN
  logic clear_start;
  logic clear_done;

  hub75_fb_clear #(
    .depth_p      (hpixel_p * vpixel_p),
    .addr_width_p (addr_width_p)
  ) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .start (clear_start),
    .busy  (clear_busy),
    .addr  (clear_addr),
    .done  (clear_done)
  );
`else
  logic unused_clear_req;

  assign unused_clear_req = i_clear_req;
  assign clear_busy       = 1'b0;
  assign clear_addr       = '0;
`endif

  // active_q keeps o_wr_ready low while held in reset so every output reads 0.
  assign o_wr_ready     = active_q && (state_q == FB_READY) && !pending_q;
  assign wr_accept      = i_wr_valid && o_wr_ready;
  assign swap_want      = i_swap_req || pending_q;
  assign o_swap_pending = pending_q;
  assign o_clear_busy   = clear_busy;

  // Next-state logic: clear wins over swap, swaps wait for frame end while scanning.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    apply_swap = 1'b0;
`ifdef HUB75_FB_CLEAR_EN
    clear_start = 1'b0;
`endif
    case (state_q)
      FB_READY: begin
`ifdef HUB75_FB_CLEAR_EN
        if (i_clear_req) begin
          clear_start = 1'b1;
          state_d     = FB_CLEAR;
          pending_d   = swap_want;
        end else
`endif
        if (swap_want) begin
          if (!o_disp_enable) begin
            apply_swap = 1'b1;
            pending_d  = 1'b0;
          end else begin
            state_d   = FB_SWAP_WAIT;
            pending_d = 1'b1;
          end
        end
      end
      FB_SWAP_WAIT: begin
        if (i_frame_end) begin
          apply_swap = 1'b1;
          pending_d  = 1'b0;
          state_d    = FB_READY;
        end
      end
`ifdef HUB75_FB_CLEAR_EN
      FB_CLEAR: begin
        if (i_swap_req) pending_d = 1'b1;
        if (clear_done) state_d = FB_READY;
      end
`endif
      default: state_d = FB_READY;
    endcase
  end

  // FSM state, latched swap request and the out-of-reset flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FB_READY;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= 1'b1;
    end
  end

  // Bank select toggles only when a swap is applied; done pulses alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_front_sel <= 1'b0;
      o_swap_done <= 1'b0;
    end else begin
      o_swap_done <= apply_swap;
      if (apply_swap) o_front_sel <= ~o_front_sel;
    end
  end

  // Capture accepted host writes; the bank is the back bank at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_we_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      wr_mask_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_we_q <= wr_accept;
      if (wr_accept) begin
        wr_bank_q <= ~o_front_sel;
        wr_addr_q <= i_wr_addr;
        wr_mask_q <= segments_p'(1) << i_wr_seg;
        wr_data_q <= i_wr_data;
      end
    end
  end

  // Scanner enable follows i_run by one cycle; frame counter counts every frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_disp_enable <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_disp_enable <= i_run;
      if (i_frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

  // A host write accepted together with a clear request is shadowed by the
  // clear, which zero-fills that same back-bank address anyway.
  assign o_mem_we        = clear_busy | wr_we_q;
  assign o_mem_wbank     = clear_busy ? ~o_front_sel : wr_bank_q;
  assign o_mem_waddr     = clear_busy ? clear_addr : wr_addr_q;
  assign o_mem_wseg_mask = clear_busy ? {segments_p{1'b1}} : wr_mask_q;
  assign o_mem_wdata     = clear_busy ? '0 : wr_data_q;

endmodule

// File: tb/tb_hub75_fb_ctrl.sv
// Self-checking bench for hub75_fb_ctrl with a behavioural model and directed
// vectors. Clear tests adapt to whether HUB75_FB_CLEAR_EN is defined.
module tb_hub75_fb_ctrl;

  localparam int PIXELS = 4096;
`ifdef HUB75_FB_CLEAR_EN
  localparam bit clear_enabled = 1'b1;
`else
  localparam bit clear_enabled = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_run, i_frame_end, i_wr_valid, i_swap_req, i_clear_req;
  logic        o_wr_ready;
  logic [11:0] i_wr_addr;
  logic [0:0]  i_wr_seg;
  logic [23:0] i_wr_data;
  logic        o_disp_enable, o_front_sel, o_mem_we, o_mem_wbank;
  logic [11:0] o_mem_waddr;
  logic [1:0]  o_mem_wseg_mask;
  logic [23:0] o_mem_wdata;
  logic        o_swap_pending, o_swap_done, o_clear_busy;
  logic [15:0] o_frame_cnt;

  int num_checks = 0;
  int num_fails  = 0;
  int num_frames = 0;

  hub75_fb_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_run           (i_run),
    .i_frame_end     (i_frame_end),
    .i_wr_valid      (i_wr_valid),
    .o_wr_ready      (o_wr_ready),
    .i_wr_addr       (i_wr_addr),
    .i_wr_seg        (i_wr_seg),
    .i_wr_data       (i_wr_data),
    .i_swap_req      (i_swap_req),
    .i_clear_req     (i_clear_req),
    .o_disp_enable   (o_disp_enable),
    .o_front_sel     (o_front_sel),
    .o_mem_we        (o_mem_we),
    .o_mem_wbank     (o_mem_wbank),
    .o_mem_waddr     (o_mem_waddr),
    .o_mem_wseg_mask (o_mem_wseg_mask),
    .o_mem_wdata     (o_mem_wdata),
    .o_swap_pending  (o_swap_pending),
    .o_swap_done     (o_swap_done),
    .o_clear_busy    (o_clear_busy),
    .o_frame_cnt     (o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of pulses from a negedge, then return all pulses to 0.
  task automatic applyStimulus(input logic frame_end, input logic wr_valid, input logic [11:0] addr,
                               input logic seg, input logic [23:0] data, input logic swap, input logic clear);
    i_frame_end = frame_end;
    i_wr_valid  = wr_valid;
    i_wr_addr   = addr;
    i_wr_seg    = seg;
    i_wr_data   = data;
    i_swap_req  = swap;
    i_clear_req = clear;
    @(negedge clk);
    i_frame_end = 1'b0;
    i_wr_valid  = 1'b0;
    i_swap_req  = 1'b0;
    i_clear_req = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: mode 0 = idle, 1 = swap waiting for frame end, 2 = clearing.
  int          m_mode;
  int          m_idx;
  bit          m_front, m_pend, m_en, m_active, m_done;
  logic [15:0] m_frames;
  bit          e_we, e_bank;
  logic [11:0] e_addr;
  logic [1:0]  e_mask;
  logic [23:0] e_data;
  bit          ready_now, front_now, accept, want;

  // Advance the model by one clock using the operational rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_front = 0; m_pend = 0; m_en = 0; m_active = 0; m_done = 0;
      m_frames = '0; e_we = 0; e_bank = 0; e_addr = '0; e_mask = '0; e_data = '0;
    end else begin
      ready_now = m_active && (m_mode == 0) && !m_pend;
      front_now = m_front;
      accept    = i_wr_valid && ready_now;
      want      = i_swap_req || m_pend;
      m_done    = 0;
      if (m_mode == 0) begin
        if (clear_enabled && i_clear_req) begin
          m_mode = 2; m_idx = 0; m_pend = want;
        end else if (want) begin
          if (!m_en) begin m_front = !m_front; m_done = 1; m_pend = 0; end
          else begin m_mode = 1; m_pend = 1; end
        end
      end else if (m_mode == 1) begin
        if (i_frame_end) begin m_front = !m_front; m_done = 1; m_pend = 0; m_mode = 0; end
      end else begin
        if (i_swap_req) m_pend = 1;
        if (m_idx == PIXELS - 1) m_mode = 0;
        else m_idx = m_idx + 1;
      end
      if (m_mode == 2) begin
        e_we = 1; e_addr = 12'(m_idx); e_mask = 2'b11; e_data = '0; e_bank = !m_front;
      end else if (accept) begin
        e_we = 1; e_addr = i_wr_addr; e_mask = 2'(1 << i_wr_seg); e_data = i_wr_data; e_bank = !front_now;
      end else begin
        e_we = 0;
      end
      if (i_frame_end) m_frames = m_frames + 16'd1;
      m_en     = i_run;
      m_active = 1;
    end
  end

  // Compare every DUT output against the model shortly after each clock edge.
  always @(posedge clk) begin
    #2;
    checkOutput("disp_enable", o_disp_enable, m_en);
    checkOutput("front_sel", o_front_sel, m_front);
    checkOutput("wr_ready", o_wr_ready, m_active && (m_mode == 0) && !m_pend);
    checkOutput("swap_pending", o_swap_pending, m_pend);
    checkOutput("swap_done", o_swap_done, m_done);
    checkOutput("clear_busy", o_clear_busy, m_mode == 2);
    checkOutput("frame_cnt", o_frame_cnt, m_frames);
    checkOutput("mem_we", o_mem_we, e_we);
    if (e_we) begin
      checkOutput("mem_waddr", o_mem_waddr, e_addr);
      checkOutput("mem_mask", o_mem_wseg_mask, e_mask);
      checkOutput("mem_wdata", o_mem_wdata, e_data);
      checkOutput("mem_wbank", o_mem_wbank, e_bank);
    end
  end

  int low_cnt, busy_cnt, zero_writes;

  initial begin
    rst_n = 1'b1; i_run = 0; i_frame_end = 0; i_wr_valid = 0; i_wr_addr = '0;
    i_wr_seg = '0; i_wr_data = '0; i_swap_req = 0; i_clear_req = 0;
    #1 rst_n = 1'b0;
    waitCycles(3);
    checkOutput("reset_front_sel", o_front_sel, 0);
    checkOutput("reset_frame_cnt", o_frame_cnt, 0);
    checkOutput("reset_mem_we", o_mem_we, 0);
    checkOutput("reset_wr_ready", o_wr_ready, 0);
    checkOutput("reset_disp_enable", o_disp_enable, 0);

    rst_n = 1'b1;
    i_run = 1'b1;
    @(negedge clk);
    checkOutput("run_disp_enable", o_disp_enable, 1);
    checkOutput("run_swap_done", o_swap_done, 0);
    checkOutput("run_pending", o_swap_pending, 0);
    checkOutput("run_clear_busy", o_clear_busy, 0);

    applyStimulus(0, 1, 12'h123, 1'b1, 24'hFF00AA, 0, 0);
    checkOutput("wr_we", o_mem_we, 1);
    checkOutput("wr_addr", o_mem_waddr, 12'h123);
    checkOutput("wr_mask", o_mem_wseg_mask, 2'b10);
    checkOutput("wr_data", o_mem_wdata, 24'hFF00AA);
    checkOutput("wr_bank", o_mem_wbank, 1);
    @(negedge clk);
    checkOutput("wr_we_single", o_mem_we, 0);

    applyStimulus(0, 0, '0, 0, '0, 1, 0);
    low_cnt = 0;
    for (int i = 1; i <= 50; i++) begin
      if (!o_wr_ready) low_cnt++;
      if (i == 50) i_frame_end = 1'b1;
      @(negedge clk);
      i_frame_end = 1'b0;
    end
    num_frames++;
    checkOutput("swapwait_ready_low_cycles", low_cnt, 50);
    checkOutput("swapwait_front_sel", o_front_sel, 1);
    checkOutput("swapwait_done", o_swap_done, 1);
    checkOutput("swapwait_ready_back", o_wr_ready, 1);
    @(negedge clk);
    checkOutput("swapwait_done_pulse", o_swap_done, 0);

    i_run = 1'b0;
    waitCycles(2);
    applyStimulus(0, 0, '0, 0, '0, 1, 0);
    checkOutput("idle_swap_front_sel", o_front_sel, 0);
    checkOutput("idle_swap_done", o_swap_done, 1);

    i_run = 1'b1;
    waitCycles(2);
    applyStimulus(0, 0, '0, 0, '0, 1, 0);
    waitCycles(3);
    checkOutput("double_pending", o_swap_pending, 1);
    applyStimulus(0, 0, '0, 0, '0, 1, 0);
    waitCycles(3);
    applyStimulus(1, 0, '0, 0, '0, 0, 0);
    num_frames++;
    checkOutput("double_front_sel", o_front_sel, 1);
    checkOutput("double_pending_clear", o_swap_pending, 0);
    waitCycles(5);
    checkOutput("double_single_toggle", o_front_sel, 1);

    i_run = 1'b0;
    waitCycles(2);
    applyStimulus(0, 1, 12'h010, 1'b0, 24'h00A5C3, 1, 0);
    checkOutput("wrswap_we", o_mem_we, 1);
    checkOutput("wrswap_old_back_bank", o_mem_wbank, 0);
    checkOutput("wrswap_front_sel", o_front_sel, 0);
    checkOutput("wrswap_mask", o_mem_wseg_mask, 2'b01);

`ifdef HUB75_FB_CLEAR_EN
    applyStimulus(0, 0, '0, 0, '0, 0, 1);
    busy_cnt = 0;
    zero_writes = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!o_clear_busy && busy_cnt > 0) break;
      if (o_clear_busy) begin
        busy_cnt++;
        if (o_mem_we && o_mem_wdata == 24'h0 && o_mem_wseg_mask == 2'b11 && o_mem_wbank) zero_writes++;
      end
      i_swap_req = (i == 10);
      @(negedge clk);
      i_swap_req = 1'b0;
    end
    checkOutput("clear_busy_cycles", busy_cnt, PIXELS);
    checkOutput("clear_zero_writes", zero_writes, PIXELS);
    checkOutput("clear_swap_latched", o_swap_pending, 1);
    checkOutput("clear_front_before", o_front_sel, 0);
    @(negedge clk);
    checkOutput("clear_then_swap", o_front_sel, 1);
    checkOutput("clear_then_done", o_swap_done, 1);
`else
    applyStimulus(0, 0, '0, 0, '0, 0, 1);
    checkOutput("noclr_busy", o_clear_busy, 0);
    checkOutput("noclr_we", o_mem_we, 0);
    waitCycles(3);
    checkOutput("noclr_ready", o_wr_ready, 1);
`endif

    checkOutput("frame_count", o_frame_cnt, num_frames);

`ifdef HUB75_FB_CLEAR_EN
    applyStimulus(0, 0, '0, 0, '0, 0, 1);
    waitCycles(100);
    checkOutput("midclear_busy", o_clear_busy, 1);
`else
    i_run = 1'b1;
    waitCycles(2);
    applyStimulus(0, 0, '0, 0, '0, 1, 0);
    waitCycles(20);
    checkOutput("midswap_pending", o_swap_pending, 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_front_sel", o_front_sel, 0);
    checkOutput("areset_frame_cnt", o_frame_cnt, 0);
    checkOutput("areset_busy", o_clear_busy, 0);
    checkOutput("areset_we", o_mem_we, 0);
    checkOutput("areset_pending", o_swap_pending, 0);
    checkOutput("areset_ready", o_wr_ready, 0);
    checkOutput("areset_disp_enable", o_disp_enable, 0);
    @(negedge clk);
    rst_n = 1'b1;
    i_run = 1'b0;
    waitCycles(3);
    checkOutput("after_reset_ready", o_wr_ready, 1);
    checkOutput("after_reset_front", o_front_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
